// File: rtl/rt_pkg.sv
// Shared defaults and types for the real-time timebase.
package rt_pkg;
  localparam int RT_PRESCALE_W = 16;
  localparam int RT_SEC_W      = 24;
  localparam int RT_SEC_DIV    = 32768;
  localparam int RT_NUM_CE     = 3;

  // Channel 0 in the LSBs.
  localparam logic [8*RT_NUM_CE-1:0] RT_CE_TAPS = {8'd15, 8'd12, 8'd7};

  typedef logic [RT_SEC_W-1:0] rt_sec_t;
endpackage

// File: rtl/rt_timebase_if.sv
// Load and snapshot handshake bundle between an RTC client and the timebase.
interface rt_timebase_if #(
  parameter int SEC_W = 24
);
  logic             load_valid;
  logic [SEC_W-1:0] load_value;
  logic             load_ready;
  logic             snap_req;
  logic             snap_valid;
  logic [SEC_W-1:0] snap_value;

  modport master (output load_valid, load_value, snap_req,
                  input  load_ready, snap_valid, snap_value);
  modport slave  (input  load_valid, load_value, snap_req,
                  output load_ready, snap_valid, snap_value);
endinterface

// File: rtl/rt_sec_counter.sv
// Seconds sub-divider and RTC counter with load handshake, snapshot and sticky wrap flag.
module rt_sec_counter
  import rt_pkg::*;
#(
  parameter int SEC_DIV = RT_SEC_DIV,
  parameter int SEC_W   = RT_SEC_W
) (
  input  logic             clk_rt,
  input  logic             reset,
  input  logic             run,
  input  logic             freeze,
  input  logic             wrap_clr,
  output logic             sec_tick,
  output logic [SEC_W-1:0] sec_count,
  output logic             sec_wrap,
  rt_timebase_if.slave     bus
);
  localparam int               SUB_W   = (SEC_DIV > 2) ? $clog2(SEC_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SEC_DIV - 1);

  logic [SUB_W-1:0] sub_cnt, sub_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic             tick_nxt, wrap_set, load_fire;

  assign load_fire = bus.load_valid & ~freeze;

  // A load overrides a coincident second boundary: no tick, no wrap.
  always_comb begin
    sub_nxt  = sub_cnt;
    sec_nxt  = sec_count;
    tick_nxt = 1'b0;
    wrap_set = 1'b0;
    if (load_fire) begin
      sec_nxt = bus.load_value;
      sub_nxt = '0;
    end else if (run) begin
      if (sub_cnt == SUB_MAX) begin
        sub_nxt  = '0;
        sec_nxt  = sec_count + 1'b1;
        tick_nxt = 1'b1;
        wrap_set = &sec_count;
      end else begin
        sub_nxt = sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rt or posedge reset) begin
    if (reset) begin
      sub_cnt        <= '0;
      sec_count      <= '0;
      sec_tick       <= 1'b0;
      sec_wrap       <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.snap_valid <= 1'b0;
      bus.snap_value <= '0;
    end else begin
      sub_cnt        <= sub_nxt;
      sec_count      <= sec_nxt;
      sec_tick       <= tick_nxt;
      sec_wrap       <= wrap_set | (sec_wrap & ~wrap_clr);
      bus.load_ready <= load_fire;
      bus.snap_valid <= bus.snap_req;
      // Capture the post-update value so the snapshot matches next cycle's sec_count.
      if (bus.snap_req) bus.snap_value <= sec_nxt;
    end
  end
endmodule

// File: rtl/rt_timebase.sv
// Real-time timebase: free-running prescaler with power-of-two CE taps plus RTC seconds path.
module rt_timebase
  import rt_pkg::*;
#(
  parameter int                    PRESCALE_W = RT_PRESCALE_W,
  parameter int                    NUM_CE     = RT_NUM_CE,
  parameter logic [8*NUM_CE-1:0]   CE_TAPS    = RT_CE_TAPS,
  parameter int                    SEC_DIV    = RT_SEC_DIV,
  parameter int                    SEC_W      = RT_SEC_W
) (
  input  logic              clk_rt,
  input  logic              reset,
  input  logic              enable,
  input  logic              freeze,
  input  logic              prescale_clr,
  output logic [NUM_CE-1:0] ce_out,
  output logic              sec_tick,
  output logic [SEC_W-1:0]  sec_count,
  output logic              sec_wrap,
  input  logic              wrap_clr,
  rt_timebase_if.slave      bus
);
  logic                  run;
  logic [PRESCALE_W-1:0] prescaler;

  assign run = enable & ~freeze;

  always_ff @(posedge clk_rt or posedge reset) begin
    if (reset)             prescaler <= '0;
    else if (prescale_clr) prescaler <= '0;
    else if (run)          prescaler <= prescaler + 1'b1;
  end

  // Pulse after the run cycle that rolls the low TAP+1 bits over.
  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    localparam int TAP = int'(CE_TAPS[8*i +: 8]);
    always_ff @(posedge clk_rt or posedge reset) begin
      if (reset) ce_out[i] <= 1'b0;
      else       ce_out[i] <= run & (&prescaler[TAP:0]);
    end
  end

  rt_sec_counter #(
    .SEC_DIV (SEC_DIV),
    .SEC_W   (SEC_W)
  ) u_sec (
    .clk_rt    (clk_rt),
    .reset     (reset),
    .run       (run),
    .freeze    (freeze),
    .wrap_clr  (wrap_clr),
    .sec_tick  (sec_tick),
    .sec_count (sec_count),
    .sec_wrap  (sec_wrap),
    .bus       (bus)
  );
endmodule
